// File: rtl/fsm_decrypt.sv
// Control FSM for ASCON-128 decryption. Steps the permutation datapath one
// round per clock through initialization, one associated-data block,
// NB_DATA_BLOCKS ciphertext blocks and finalization. AD and ciphertext words
// are taken from the datapath cipher bus with a valid/ready handshake.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | waiting for start_i; every output low except tag_valid_o
// INIT      | 12 initialization rounds (rnd 0..11), key XOR at the end
// AD_WAIT   | waiting for the AD word; transfer runs round 6
// AD        | AD rounds 7..11, domain-separation bit at the end
// DATA_WAIT | waiting for a ciphertext word; transfer runs round 6,
//           | or round 0 of finalization for the last block
// DATA      | ciphertext rounds 7..11, then next block
// FINAL     | finalization rounds 1..11, key XOR and tag capture at the end
// DONE      | single-cycle completion pulse, tag marked valid

module fsm_decrypt #(
    // Ciphertext blocks per message; legal range 1..15 (4-bit block counter).
    parameter int NB_DATA_BLOCKS = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       word_valid_i,
    output logic       word_ready_o,
    output logic       sel_mux_perm_o,
    output logic       sel_muxData_perm_o,
    output logic [3:0] round_o,
    output logic       write_enable_data_o,
    output logic       write_enable_cipher_o,
    output logic       write_enable_tag_o,
    output logic       en_xor_begin_data_o,
    output logic       en_xor_begin_key_o,
    output logic       en_xor_end_lsb_o,
    output logic       en_xor_end_key_o,
    output logic       plain_valid_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       tag_valid_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_AD_WAIT,
        S_AD,
        S_DATA_WAIT,
        S_DATA,
        S_FINAL,
        S_DONE
    } state_t;

    localparam logic [3:0] LAST_RND   = 4'd11;
    localparam logic [3:0] PB_FIRST   = 4'd6;
    localparam logic [3:0] PB_SECOND  = 4'd7;
    localparam logic [3:0] PA_FIRST   = 4'd0;
    localparam logic [3:0] FIN_SECOND = 4'd1;
    localparam logic [3:0] LAST_BLK   = 4'(NB_DATA_BLOCKS - 1);

    state_t     state_q;
    logic [3:0] rnd_q;
    logic [3:0] blk_q;
    logic       plain_valid_q;
    logic       tag_valid_q;

    logic       in_wait;
    logic       xfer;
    logic       last_rnd;
    logic       last_blk;

    assign in_wait  = (state_q == S_AD_WAIT) || (state_q == S_DATA_WAIT);
    assign xfer     = word_valid_i & in_wait;
    assign last_rnd = (rnd_q == LAST_RND);
    assign last_blk = (blk_q == LAST_BLK);

    // State, round/block counters and the two registered status flags.
    // rnd is reloaded on every state entry so it never wraps.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            rnd_q         <= 4'd0;
            blk_q         <= 4'd0;
            plain_valid_q <= 1'b0;
            tag_valid_q   <= 1'b0;
        end else begin
            plain_valid_q <= write_enable_cipher_o;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q     <= S_INIT;
                        rnd_q       <= 4'd0;
                        blk_q       <= 4'd0;
                        tag_valid_q <= 1'b0;
                    end
                end
                S_INIT: begin
                    if (last_rnd) begin
                        state_q <= S_AD_WAIT;
                        rnd_q   <= 4'd0;
                    end else begin
                        rnd_q <= rnd_q + 4'd1;
                    end
                end
                S_AD_WAIT: begin
                    if (xfer) begin
                        state_q <= S_AD;
                        rnd_q   <= PB_SECOND;
                    end
                end
                S_AD: begin
                    if (last_rnd) begin
                        state_q <= S_DATA_WAIT;
                        rnd_q   <= 4'd0;
                        blk_q   <= 4'd0;
                    end else begin
                        rnd_q <= rnd_q + 4'd1;
                    end
                end
                S_DATA_WAIT: begin
                    if (xfer) begin
                        if (last_blk) begin
                            // Last block skips pb and folds straight into pa.
                            state_q <= S_FINAL;
                            rnd_q   <= FIN_SECOND;
                        end else begin
                            state_q <= S_DATA;
                            rnd_q   <= PB_SECOND;
                        end
                    end
                end
                S_DATA: begin
                    if (last_rnd) begin
                        state_q <= S_DATA_WAIT;
                        rnd_q   <= 4'd0;
                        blk_q   <= blk_q + 4'd1;
                    end else begin
                        rnd_q <= rnd_q + 4'd1;
                    end
                end
                S_FINAL: begin
                    if (last_rnd) begin
                        state_q <= S_DONE;
                        rnd_q   <= 4'd0;
                    end else begin
                        rnd_q <= rnd_q + 4'd1;
                    end
                end
                S_DONE: begin
                    state_q     <= S_IDLE;
                    rnd_q       <= 4'd0;
                    tag_valid_q <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                    rnd_q   <= 4'd0;
                    blk_q   <= 4'd0;
                end
            endcase
        end
    end

    // Datapath controls decoded from state, counters and the bus handshake.
    // round_o reads 0 in cycles where no round is executed.
    always_comb begin
        word_ready_o          = in_wait;
        sel_mux_perm_o        = 1'b0;
        sel_muxData_perm_o    = 1'b0;
        round_o               = 4'd0;
        write_enable_data_o   = 1'b0;
        write_enable_cipher_o = 1'b0;
        write_enable_tag_o    = 1'b0;
        en_xor_begin_data_o   = 1'b0;
        en_xor_begin_key_o    = 1'b0;
        en_xor_end_lsb_o      = 1'b0;
        en_xor_end_key_o      = 1'b0;
        busy_o                = (state_q != S_IDLE) && (state_q != S_DONE);
        done_o                = (state_q == S_DONE);
        case (state_q)
            S_INIT: begin
                write_enable_data_o = 1'b1;
                round_o             = rnd_q;
                // Only the very first round loads the external initial state.
                sel_mux_perm_o      = (rnd_q != 4'd0);
                en_xor_end_key_o    = last_rnd;
            end
            S_AD_WAIT: begin
                if (xfer) begin
                    write_enable_data_o = 1'b1;
                    sel_mux_perm_o      = 1'b1;
                    round_o             = PB_FIRST;
                    en_xor_begin_data_o = 1'b1;
                end
            end
            S_AD: begin
                write_enable_data_o = 1'b1;
                sel_mux_perm_o      = 1'b1;
                round_o             = rnd_q;
                en_xor_end_lsb_o    = last_rnd;
            end
            S_DATA_WAIT: begin
                if (xfer) begin
                    write_enable_data_o   = 1'b1;
                    sel_mux_perm_o        = 1'b1;
                    sel_muxData_perm_o    = 1'b1;
                    write_enable_cipher_o = 1'b1;
                    en_xor_begin_data_o   = 1'b1;
                    en_xor_begin_key_o    = last_blk;
                    round_o               = last_blk ? PA_FIRST : PB_FIRST;
                end
            end
            S_DATA: begin
                write_enable_data_o = 1'b1;
                sel_mux_perm_o      = 1'b1;
                round_o             = rnd_q;
            end
            S_FINAL: begin
                write_enable_data_o = 1'b1;
                sel_mux_perm_o      = 1'b1;
                round_o             = rnd_q;
                en_xor_end_key_o    = last_rnd;
                write_enable_tag_o  = last_rnd;
            end
            default: begin
                word_ready_o = in_wait;
            end
        endcase
    end

    assign plain_valid_o = plain_valid_q;
    assign tag_valid_o   = tag_valid_q;

endmodule

// File: tb/tb_fsm_decrypt.sv
// Scoreboard bench for fsm_decrypt. A message-level model lays out the
// expected round schedule (init, AD block, ciphertext blocks, finalization)
// as a cycle-stamped queue; a monitor pops and compares every busy/done cycle.
module tb_fsm_decrypt;

    typedef struct packed {
        int          cyc;
        logic [17:0] v;
    } exp_t;

    logic clk = 1'b0;
    logic rst_i;
    logic start4, valid4, start1, valid1;

    logic ready4, selm4, seld4, wed4, wec4, wet4, xbd4, xbk4, xel4, xek4, pv4, busy4, done4, tag4;
    logic ready1, selm1, seld1, wed1, wec1, wet1, xbd1, xbk1, xel1, xek1, pv1, busy1, done1, tag1;
    logic [3:0] rnd4, rnd1;
    logic [17:0] got4, got1;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    exp_t q4[$];
    exp_t q1[$];
    exp_t e4, e1;
    logic [1:0] vmode [0:8191];
    int stl [0:15];
    logic exp_tag4 = 1'b0;
    logic exp_tag1 = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fsm_decrypt #(.NB_DATA_BLOCKS(4)) dut4 (
        .clk_i(clk), .rst_i(rst_i), .start_i(start4), .word_valid_i(valid4),
        .word_ready_o(ready4), .sel_mux_perm_o(selm4), .sel_muxData_perm_o(seld4),
        .round_o(rnd4), .write_enable_data_o(wed4), .write_enable_cipher_o(wec4),
        .write_enable_tag_o(wet4), .en_xor_begin_data_o(xbd4), .en_xor_begin_key_o(xbk4),
        .en_xor_end_lsb_o(xel4), .en_xor_end_key_o(xek4), .plain_valid_o(pv4),
        .busy_o(busy4), .done_o(done4), .tag_valid_o(tag4));

    fsm_decrypt #(.NB_DATA_BLOCKS(1)) dut1 (
        .clk_i(clk), .rst_i(rst_i), .start_i(start1), .word_valid_i(valid1),
        .word_ready_o(ready1), .sel_mux_perm_o(selm1), .sel_muxData_perm_o(seld1),
        .round_o(rnd1), .write_enable_data_o(wed1), .write_enable_cipher_o(wec1),
        .write_enable_tag_o(wet1), .en_xor_begin_data_o(xbd1), .en_xor_begin_key_o(xbk1),
        .en_xor_end_lsb_o(xel1), .en_xor_end_key_o(xek1), .plain_valid_o(pv1),
        .busy_o(busy1), .done_o(done1), .tag_valid_o(tag1));

    assign got4 = {ready4, selm4, seld4, rnd4, wed4, wec4, wet4, xbd4, xbk4, xel4, xek4, pv4, busy4, done4, tag4};
    assign got1 = {ready1, selm1, seld1, rnd1, wed1, wec1, wet1, xbd1, xbk1, xel1, xek1, pv1, busy1, done1, tag1};

    function automatic logic [17:0] mk(input logic ready, input logic selm, input logic seld,
                                       input logic [3:0] rnd, input logic wed, input logic wec,
                                       input logic wet, input logic xbd, input logic xbk,
                                       input logic xel, input logic xek, input logic pv,
                                       input logic busy, input logic done, input logic tag);
        return {ready, selm, seld, rnd, wed, wec, wet, xbd, xbk, xel, xek, pv, busy, done, tag};
    endfunction

    function automatic logic [17:0] idle_vec(input logic tag);
        return mk(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, tag);
    endfunction

    task automatic push(input int which, input int t, input logic [17:0] v);
        exp_t e;
        e.cyc = t;
        e.v   = v;
        if (which == 0) q4.push_back(e);
        else            q1.push_back(e);
    endtask

    task automatic set_vmode(input int which, input int t, input logic [1:0] m);
        if (which == 0 && t < 8192) vmode[t] = m;
    endtask

    // Message schedule: 12 init rounds, then per input word an optional stall
    // (stl[k] cycles) followed by its rounds; word 0 is AD, words 1..nb are
    // ciphertext, the last one running the full 12-round finalization.
    task automatic plan(input int which, input int s, input int nb, output int done_c);
        int  t;
        int  r0;
        logic first, last, h;
        t = s + 1;
        for (int r = 0; r < 12; r++) begin
            push(which, t, mk(1'b0, r != 0, 1'b0, 4'(r), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                              1'b0, r == 11, 1'b0, 1'b1, 1'b0, 1'b0));
            set_vmode(which, t, 2'd0);
            t++;
        end
        for (int k = 0; k <= nb; k++) begin
            first = (k == 0);
            last  = (k == nb);
            for (int i = 0; i < stl[k]; i++) begin
                push(which, t, mk(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
                set_vmode(which, t, 2'd2);
                t++;
            end
            r0 = last ? 0 : 6;
            for (int r = r0; r < 12; r++) begin
                h = (r == r0);
                push(which, t, mk(h, 1'b1, h && !first, 4'(r), 1'b1, h && !first,
                                  last && r == 11, h, h && last, first && r == 11,
                                  last && r == 11, (r == r0 + 1) && !first, 1'b1, 1'b0, 1'b0));
                set_vmode(which, t, h ? 2'd1 : 2'd0);
                t++;
            end
        end
        push(which, t, mk(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                          1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        set_vmode(which, t, 2'd0);
        done_c = t;
    endtask

    function automatic logic pick(input int c, input int vn);
        if (c < 8192 && vmode[c] == 2'd1) return 1'b1;
        if (c < 8192 && vmode[c] == 2'd2) return 1'b0;
        if (vn == 0) return 1'b0;
        if (vn == 1) return 1'b1;
        return 1'($urandom % 2);
    endfunction

    task automatic check(input string nm, input logic [17:0] got, input logic [17:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
        end
    endtask

    task automatic check_int(input string nm, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", nm, cyc, got, exp);
        end
    endtask

    // Monitor: every busy or done cycle must match the next scheduled entry.
    always @(negedge clk) begin
        if (busy4 === 1'b1 || done4 === 1'b1) begin
            n_vec++;
            if (q4.size() == 0) begin
                n_err++;
                $display("FAIL nb4_unexpected cyc=%0d got=%h exp=none", cyc, got4);
            end else begin
                e4 = q4.pop_front();
                if (e4.cyc != cyc || got4 !== e4.v) begin
                    n_err++;
                    $display("FAIL nb4_sched cyc=%0d got=%h exp_cyc=%0d exp=%h", cyc, got4, e4.cyc, e4.v);
                end
            end
        end
        if (busy1 === 1'b1 || done1 === 1'b1) begin
            n_vec++;
            if (q1.size() == 0) begin
                n_err++;
                $display("FAIL nb1_unexpected cyc=%0d got=%h exp=none", cyc, got1);
            end else begin
                e1 = q1.pop_front();
                if (e1.cyc != cyc || got1 !== e1.v) begin
                    n_err++;
                    $display("FAIL nb1_sched cyc=%0d got=%h exp_cyc=%0d exp=%h", cyc, got1, e1.cyc, e1.v);
                end
            end
        end
    end

    // One NB=4 message. vn: valid outside wait states (0 low, 1 high, 2 random);
    // sn: random start_i pulses while busy; do_rst: reset at FINAL round 5.
    task automatic run_msg(input int vn, input logic sn, input logic do_rst);
        int s, dc, rc, last;
        s = cyc;
        plan(0, s, 4, dc);
        start4   = 1'b1;
        valid4   = pick(s, vn);
        exp_tag4 = 1'b0;
        last     = dc;
        rc       = -1;
        if (do_rst) begin
            rc   = dc - 7;
            last = rc;
            while (q4.size() > 0 && q4[$].cyc > rc) void'(q4.pop_back());
        end
        for (int c = s + 1; c <= last; c++) begin
            @(posedge clk); #1;
            start4 = sn ? 1'($urandom % 2) : 1'b0;
            valid4 = pick(c, vn);
            if (do_rst && c == rc) rst_i = 1'b1;
        end
        @(posedge clk); #1;
        start4 = 1'b0;
        valid4 = pick(last + 1, vn);
        rst_i  = 1'b0;
        if (!do_rst) exp_tag4 = 1'b1;
        @(negedge clk);
        check(do_rst ? "after_reset" : "after_done", got4, idle_vec(exp_tag4));
        check_int("nb4_queue_drained", q4.size(), 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            start4 = 1'b0;
            start1 = 1'b0;
            valid4 = 1'($urandom % 2);
            valid1 = 1'($urandom % 2);
            @(negedge clk);
            check("idle_nb4", got4, idle_vec(exp_tag4));
            check("idle_nb1", got1, idle_vec(exp_tag1));
        end
    endtask

    task automatic run_nb1();
        int s, dc;
        s = cyc;
        plan(1, s, 1, dc);
        start1   = 1'b1;
        valid1   = 1'b1;
        exp_tag1 = 1'b0;
        for (int c = s + 1; c <= dc; c++) begin
            @(posedge clk); #1;
            start1 = 1'b0;
        end
        @(posedge clk); #1;
        valid1   = 1'b0;
        exp_tag1 = 1'b1;
        @(negedge clk);
        check("nb1_after_done", got1, idle_vec(1'b1));
        check_int("nb1_done_latency", dc - s, 31);
        check_int("nb1_queue_drained", q1.size(), 0);
    endtask

    task automatic zero_stalls();
        for (int k = 0; k < 16; k++) stl[k] = 0;
    endtask

    task automatic rand_stalls();
        for (int k = 0; k < 16; k++) stl[k] = $urandom_range(0, 4);
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) vmode[i] = 2'd0;
        rst_i  = 1'b1;
        start4 = 1'b0;
        valid4 = 1'b0;
        start1 = 1'b0;
        valid1 = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("reset_nb4", got4, idle_vec(1'b0));
        check("reset_nb1", got1, idle_vec(1'b0));
        @(posedge clk); #1;
        rst_i = 1'b0;
        @(negedge clk);

        zero_stalls();
        run_msg(1, 1'b0, 1'b0);

        // Back-to-back with start/valid noise outside wait states.
        run_msg(2, 1'b1, 1'b0);
        idle(3);

        zero_stalls();
        stl[0] = 5;
        stl[2] = 5;
        run_msg(1, 1'b0, 1'b0);

        rand_stalls();
        run_msg(2, 1'b1, 1'b1);
        idle(2);

        for (int m = 0; m < 6; m++) begin
            rand_stalls();
            run_msg(2, 1'($urandom % 2), 1'b0);
            if (($urandom % 2) == 0) idle($urandom_range(1, 3));
        end

        zero_stalls();
        run_nb1();
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
